m92_sound_latch: RTL and testbench

Main-CPU ↔ sound-CPU command/reply mailbox for the M92/M84 core. Consumes the `snd_latch1_wr` / `snd_latch2_wr` strobes produced by the main-CPU address decoder, holds the command byte for the sound CPU and raises its interrupt. It also carries the sound CPU's reply byte back to the main CPU with its own interrupt, and generates the sound-CPU reset pulse.

---
 rtl/m92_sound_latch.sv | 157 +++++++++++++++
 tb/tb_m92_sound_latch.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/m92_sound_latch.sv
// M92/M84 main<->sound CPU command/reply mailbox with sound-CPU reset pulse.
// Define M92_SNDLATCH_FIFO_EN to replace the command register with a FIFO.
module m92_sound_latch #(
    parameter int RESET_CYCLES = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic [7:0] main_dout,
    input  logic       snd_latch1_wr,
    input  logic       snd_latch2_wr,
    input  logic       main_reply_rd,
    output logic [7:0] main_reply,
    output logic       main_irq,
    input  logic       snd_latch_rd,
    output logic [7:0] snd_latch_dout,
    output logic       snd_irq,
    input  logic       snd_reply_wr,
    input  logic [7:0] snd_reply_din,
    output logic       snd_reset,
    output logic       overrun
);

    localparam int CW = $clog2(RESET_CYCLES + 1);

    // bit order: {reply_rd, reply_wr, latch_rd, latch2_wr, latch1_wr}
    logic [4:0]    r_stb;
    logic [4:0]    r_stb_d;
    logic [4:0]    w_rise;
    logic [4:0]    w_fall;
    logic [CW-1:0] r_cnt;
    logic          w_busy;
    logic          w_l2;
    logic          w_wr;
    logic          w_rd;
    logic          w_rep;
    logic          w_rrd;
    logic [7:0]    r_reply;
    logic          r_main_irq;
    logic          r_overrun;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_stb   <= '0;
            r_stb_d <= '0;
        end else begin
            r_stb   <= {main_reply_rd, snd_reply_wr, snd_latch_rd,
                        snd_latch2_wr, snd_latch1_wr};
            r_stb_d <= r_stb;
        end
    end

    assign w_rise = r_stb & ~r_stb_d;
    assign w_fall = ~r_stb & r_stb_d;
    assign w_busy = (r_cnt != '0);
    // sound reset wins over a command written in the same cycle
    assign w_l2   = w_rise[1];
    assign w_wr   = w_rise[0] & ~w_busy & ~w_l2;
    assign w_rd   = w_fall[2] & ~w_busy;
    assign w_rep  = w_rise[3] & ~w_busy;
    assign w_rrd  = w_fall[4];

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (w_l2) begin
            r_cnt <= CW'(RESET_CYCLES);
        end else if (w_busy) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_reply    <= 8'h00;
            r_main_irq <= 1'b0;
        end else if (w_rep) begin
            r_reply    <= snd_reply_din;
            r_main_irq <= 1'b1;
        end else if (w_rrd) begin
            r_main_irq <= 1'b0;
        end
    end

`ifdef M92_SNDLATCH_FIFO_EN
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [PW:0]   r_count;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;

    assign w_full  = (r_count == (PW+1)'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = w_wr & ~w_full;
    assign w_pop   = w_rd & ~w_empty;

    always_ff @(posedge clk_sys) begin
        if (w_push) begin
            r_mem[r_wp] <= main_dout;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n || w_l2) begin
            r_wp      <= '0;
            r_rp      <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push) r_wp <= r_wp + PW'(1);
            if (w_pop)  r_rp <= r_rp + PW'(1);
            if (w_push && !w_pop)
                r_count <= r_count + (PW+1)'(1);
            else if (w_pop && !w_push)
                r_count <= r_count - (PW+1)'(1);
            if (w_wr && w_full) r_overrun <= 1'b1;
        end
    end

    assign snd_latch_dout = w_empty ? 8'hFF : r_mem[r_rp];
    assign snd_irq        = ~w_empty;
`else
    logic [7:0] r_cmd;
    logic       r_pending;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_cmd     <= 8'h00;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_l2) begin
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_wr) begin
            r_cmd     <= main_dout;
            r_pending <= 1'b1;
            if (r_pending) r_overrun <= 1'b1;
        end else if (w_rd) begin
            r_pending <= 1'b0;
        end
    end

    assign snd_latch_dout = r_cmd;
    assign snd_irq        = r_pending;
`endif

    assign main_reply = r_reply;
    assign main_irq   = r_main_irq;
    assign snd_reset  = w_busy;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_m92_sound_latch.sv
// Directed bench for m92_sound_latch; follows M92_SNDLATCH_FIFO_EN if defined.
// Inputs change 1ns after a rising edge; outputs are checked at the same point.
module tb_m92_sound_latch;

    logic       clk_sys = 1'b0;
    logic       reset_n;
    logic [7:0] main_dout;
    logic       snd_latch1_wr;
    logic       snd_latch2_wr;
    logic       main_reply_rd;
    logic [7:0] main_reply;
    logic       main_irq;
    logic       snd_latch_rd;
    logic [7:0] snd_latch_dout;
    logic       snd_irq;
    logic       snd_reply_wr;
    logic [7:0] snd_reply_din;
    logic       snd_reset;
    logic       overrun;

    int n_cmp = 0;
    int n_err = 0;

    m92_sound_latch #(.RESET_CYCLES(16), .FIFO_DEPTH(4)) dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .main_dout     (main_dout),
        .snd_latch1_wr (snd_latch1_wr),
        .snd_latch2_wr (snd_latch2_wr),
        .main_reply_rd (main_reply_rd),
        .main_reply    (main_reply),
        .main_irq      (main_irq),
        .snd_latch_rd  (snd_latch_rd),
        .snd_latch_dout(snd_latch_dout),
        .snd_irq       (snd_irq),
        .snd_reply_wr  (snd_reply_wr),
        .snd_reply_din (snd_reply_din),
        .snd_reset     (snd_reset),
        .overrun       (overrun)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cmd_pulse(input logic [7:0] d);
        main_dout     = d;
        snd_latch1_wr = 1'b1;
        tick();
        snd_latch1_wr = 1'b0;
        tick();
        tick();
    endtask

    task automatic rd_pulse();
        snd_latch_rd = 1'b1;
        tick();
        snd_latch_rd = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        reset_n       = 1'b0;
        main_dout     = 8'h00;
        snd_latch1_wr = 1'b0;
        snd_latch2_wr = 1'b0;
        main_reply_rd = 1'b0;
        snd_latch_rd  = 1'b0;
        snd_reply_wr  = 1'b0;
        snd_reply_din = 8'h00;
        tick();
        tick();
`ifdef M92_SNDLATCH_FIFO_EN
        chk("rst_dout", snd_latch_dout, 8'hFF);
`else
        chk("rst_dout", snd_latch_dout, 8'h00);
`endif
        chk("rst_reply", main_reply, 8'h00);
        chk("rst_flags", {4'h0, snd_irq, main_irq, snd_reset, overrun}, 8'h00);
        reset_n = 1'b1;
        tick();

        // command 3A, strobe held 4 cycles
        main_dout     = 8'h3A;
        snd_latch1_wr = 1'b1;
        tick();
        chk("cmd_irq_n1", {7'h0, snd_irq}, 8'h00);
        tick();
        chk("cmd_irq_n2", {7'h0, snd_irq}, 8'h01);
        chk("cmd_dout", snd_latch_dout, 8'h3A);
        tick();
        tick();
        snd_latch1_wr = 1'b0;
        main_dout     = 8'h00;
        tick();
        chk("held_no_ovr", {7'h0, overrun}, 8'h00);
        snd_latch_rd = 1'b1;
        tick();
        snd_latch_rd = 1'b0;
        tick();
        chk("rd_irq_n1", {7'h0, snd_irq}, 8'h01);
        tick();
        chk("rd_irq_n2", {7'h0, snd_irq}, 8'h00);

`ifdef M92_SNDLATCH_FIFO_EN
        for (int i = 1; i <= 5; i++) cmd_pulse(8'(i));
        chk("fifo_ovr", {7'h0, overrun}, 8'h01);
        chk("fifo_irq", {7'h0, snd_irq}, 8'h01);
        chk("fifo_head1", snd_latch_dout, 8'h01);
        rd_pulse();
        chk("fifo_head2", snd_latch_dout, 8'h02);
        rd_pulse();
        chk("fifo_head3", snd_latch_dout, 8'h03);
        rd_pulse();
        chk("fifo_head4", snd_latch_dout, 8'h04);
        rd_pulse();
        chk("fifo_empty_dout", snd_latch_dout, 8'hFF);
        chk("fifo_empty_irq", {7'h0, snd_irq}, 8'h00);
        rd_pulse();
        chk("fifo_pop_empty", snd_latch_dout, 8'hFF);
`else
        cmd_pulse(8'h10);
        chk("one_no_ovr", {7'h0, overrun}, 8'h00);
        cmd_pulse(8'h20);
        chk("two_dout", snd_latch_dout, 8'h20);
        chk("two_ovr", {7'h0, overrun}, 8'h01);
        chk("two_irq", {7'h0, snd_irq}, 8'h01);
        rd_pulse();
        chk("two_rd_irq", {7'h0, snd_irq}, 8'h00);
        chk("ovr_sticky", {7'h0, overrun}, 8'h01);
`endif

        // reply path
        snd_reply_din = 8'hC5;
        snd_reply_wr  = 1'b1;
        tick();
        chk("rep_irq_n1", {7'h0, main_irq}, 8'h00);
        tick();
        chk("rep_irq_n2", {7'h0, main_irq}, 8'h01);
        chk("rep_data", main_reply, 8'hC5);
        snd_reply_wr  = 1'b0;
        main_reply_rd = 1'b1;
        tick();
        main_reply_rd = 1'b0;
        tick();
        tick();
        chk("rep_clr", {7'h0, main_irq}, 8'h00);
        // reply write rising coincides with reply read falling
        main_reply_rd = 1'b1;
        tick();
        main_reply_rd = 1'b0;
        snd_reply_din = 8'h5C;
        snd_reply_wr  = 1'b1;
        tick();
        tick();
        chk("rep_set_wins", {7'h0, main_irq}, 8'h01);
        chk("rep_data2", main_reply, 8'h5C);
        snd_reply_wr = 1'b0;

        // sound reset pulse
        cmd_pulse(8'hAA);
        chk("pre_rst_irq", {7'h0, snd_irq}, 8'h01);
        snd_latch2_wr = 1'b1;
        tick();
        chk("srst_n1", {7'h0, snd_reset}, 8'h00);
        snd_latch2_wr = 1'b0;
        tick();
        chk("srst_on", {7'h0, snd_reset}, 8'h01);
        chk("srst_irq", {7'h0, snd_irq}, 8'h00);
        chk("srst_ovr", {7'h0, overrun}, 8'h00);
        main_dout     = 8'h77;
        snd_latch1_wr = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (i == 1) snd_latch1_wr = 1'b0;
            chk("srst_hold", {7'h0, snd_reset}, 8'h01);
        end
        tick();
        chk("srst_off", {7'h0, snd_reset}, 8'h00);
        chk("srst_drop_irq", {7'h0, snd_irq}, 8'h00);
        chk("srst_drop_ovr", {7'h0, overrun}, 8'h00);
        chk("srst_keep_rep", main_reply, 8'h5C);
        chk("srst_keep_mirq", {7'h0, main_irq}, 8'h01);
`ifdef M92_SNDLATCH_FIFO_EN
        chk("srst_fifo_dout", snd_latch_dout, 8'hFF);
`endif

        // synchronous reset while loaded and counting
        cmd_pulse(8'h11);
        cmd_pulse(8'h22);
        cmd_pulse(8'h33);
        chk("mid_irq", {7'h0, snd_irq}, 8'h01);
        snd_latch2_wr = 1'b1;
        tick();
        tick();
        chk("mid_srst", {7'h0, snd_reset}, 8'h01);
        snd_latch2_wr = 1'b0;
        reset_n       = 1'b0;
        tick();
`ifdef M92_SNDLATCH_FIFO_EN
        chk("mid_rst_dout", snd_latch_dout, 8'hFF);
`else
        chk("mid_rst_dout", snd_latch_dout, 8'h00);
`endif
        chk("mid_rst_reply", main_reply, 8'h00);
        chk("mid_rst_flags",
            {4'h0, snd_irq, main_irq, snd_reset, overrun}, 8'h00);
        reset_n = 1'b1;
        tick();
        tick();
        chk("post_rst_srst", {7'h0, snd_reset}, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
